fe_pattern_match: RTL and testbench

- Sits directly upstream of the front-end capture stage in the fe_clk domain.
- Consumes the capture stage's pattern-match byte stream (pm_data/pm_wr), compares a sliding window of the most recent bytes against a masked pattern, and produces the capture-enable that gates front-end capture.
- Supports an optional post-match trigger delay and a software force-capture.

---
 rtl/fe_pattern_match.sv | 122 ++++++++++++
 tb/tb_fe_pattern_match.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fe_pattern_match.sv
// fe_pattern_match: masked sliding-window byte matcher that produces the
// front-end capture-enable, with an optional post-match trigger delay and a
// software force-capture. All logic is clocked by fe_clk.
module fe_pattern_match #(
  parameter int pBYTES       = 8,
  parameter int pDELAY_WIDTH = 20
) (
  input  logic                    fe_clk,
  input  logic                    reset_i,
  input  logic [7:0]              I_pm_data,
  input  logic                    I_pm_wr,
  input  logic                    I_arm,
  input  logic [8*pBYTES-1:0]     I_pattern,
  input  logic [8*pBYTES-1:0]     I_mask,
  input  logic [pDELAY_WIDTH-1:0] I_trigger_delay,
  input  logic                    I_capture_now,
  output logic                    O_match,
  output logic                    O_capture_enable,
  output logic                    O_armed,
  output logic [1:0]              O_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DELAY   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t                   state_q;
  logic                     arm_q;
  logic [pBYTES-1:0][7:0]   win_q;
  logic [pBYTES-1:0]        fill_q;
  logic [8*pBYTES-1:0]      pat_q;
  logic [8*pBYTES-1:0]      mask_q;
  logic [pDELAY_WIDTH-1:0]  delay_q;
  logic [pDELAY_WIDTH-1:0]  cnt_q;
  logic                     match_q;

  logic                     rise;
  logic                     match_comb;
  logic                     trig;
  logic [pBYTES-1:0]        pos_ok;

  assign rise = I_arm & ~arm_q;

  // A position passes when it is don't-care, or when it holds a received
  // byte that agrees with the latched pattern on every enabled bit.
  for (genvar g = 0; g < pBYTES; g++) begin : g_pos
    assign pos_ok[g] = (mask_q[8*g +: 8] == 8'h00) ||
                       (fill_q[g] &&
                        (((win_q[g] ^ pat_q[8*g +: 8]) & mask_q[8*g +: 8]) == 8'h00));
  end

  assign match_comb = &pos_ok;
  assign trig       = match_comb | I_capture_now;

  // Arm edge detect, window shifting, configuration latch and trigger FSM.
  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state_q <= IDLE;
      arm_q   <= 1'b0;
      win_q   <= '0;
      fill_q  <= '0;
      pat_q   <= '0;
      mask_q  <= '0;
      delay_q <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      arm_q   <= I_arm;
      match_q <= 1'b0;
      // Disarm takes priority over every other transition, including a match.
      if ((state_q != IDLE) && !I_arm) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rise) begin
              pat_q   <= I_pattern;
              mask_q  <= I_mask;
              delay_q <= I_trigger_delay;
              win_q   <= '0;
              fill_q  <= '0;
              state_q <= ARMED;
            end
          end
          ARMED: begin
            if (I_pm_wr) begin
              win_q  <= {win_q[pBYTES-2:0], I_pm_data};
              fill_q <= {fill_q[pBYTES-2:0], 1'b1};
            end
            if (trig) begin
              match_q <= 1'b1;
              if (delay_q == '0) begin
                state_q <= CAPTURE;
              end else begin
                state_q <= DELAY;
                cnt_q   <= delay_q - 1'b1;
              end
            end
          end
          DELAY: begin
            if (cnt_q == '0) begin
              state_q <= CAPTURE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          CAPTURE: state_q <= CAPTURE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign O_match          = match_q;
  assign O_capture_enable = (state_q == CAPTURE);
  assign O_armed          = (state_q != IDLE);
  assign O_state          = state_q;

endmodule

// File: tb/tb_fe_pattern_match.sv
// Testbench for fe_pattern_match: directed scenarios plus randomized rounds,
// every cycle checked against a history-queue / trigger-time reference model.
module tb_fe_pattern_match;

  localparam int NB = 8;
  localparam int DW = 20;

  logic            fe_clk = 1'b0;
  logic            reset_i;
  logic [7:0]      I_pm_data;
  logic            I_pm_wr;
  logic            I_arm;
  logic [8*NB-1:0] I_pattern;
  logic [8*NB-1:0] I_mask;
  logic [DW-1:0]   I_trigger_delay;
  logic            I_capture_now;
  logic            O_match;
  logic            O_capture_enable;
  logic            O_armed;
  logic [1:0]      O_state;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit              m_armed;
  bit              m_arm_prev;
  int              m_trig;
  int              m_cyc;
  int              m_D;
  logic [8*NB-1:0] m_pat;
  logic [8*NB-1:0] m_mask;
  logic [7:0]      m_hist[$];

  fe_pattern_match #(.pBYTES(NB), .pDELAY_WIDTH(DW)) dut (
    .fe_clk           (fe_clk),
    .reset_i          (reset_i),
    .I_pm_data        (I_pm_data),
    .I_pm_wr          (I_pm_wr),
    .I_arm            (I_arm),
    .I_pattern        (I_pattern),
    .I_mask           (I_mask),
    .I_trigger_delay  (I_trigger_delay),
    .I_capture_now    (I_capture_now),
    .O_match          (O_match),
    .O_capture_enable (O_capture_enable),
    .O_armed          (O_armed),
    .O_state          (O_state)
  );

  always #5 fe_clk = ~fe_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pattern holds when every masked byte has been received and agrees.
  function automatic bit model_match();
    for (int i = 0; i < NB; i++) begin
      logic [7:0] mb;
      mb = m_mask[8*i +: 8];
      if (mb != 8'h00) begin
        if (i >= m_hist.size()) return 1'b0;
        if (((m_hist[i] ^ m_pat[8*i +: 8]) & mb) != 8'h00) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic tick();
    int          k;
    logic [31:0] e_state;
    @(posedge fe_clk);
    if (reset_i) begin
      m_armed = 0; m_arm_prev = 0; m_trig = -1; m_hist.delete();
    end else begin
      if (m_armed && !I_arm) begin
        m_armed = 0; m_trig = -1;
      end else if (!m_armed) begin
        if (I_arm && !m_arm_prev) begin
          m_armed = 1; m_trig = -1; m_hist.delete();
          m_pat = I_pattern; m_mask = I_mask; m_D = int'(I_trigger_delay);
        end
      end else if (m_trig < 0) begin
        if (model_match() || I_capture_now) m_trig = m_cyc;
        if (I_pm_wr) begin
          m_hist.push_front(I_pm_data);
          if (m_hist.size() > NB) void'(m_hist.pop_back());
        end
      end
      m_arm_prev = I_arm;
    end
    m_cyc++;
    #1;
    k = m_cyc - m_trig;
    if (!m_armed)         e_state = 32'd0;
    else if (m_trig < 0)  e_state = 32'd1;
    else if (k > m_D)     e_state = 32'd3;
    else                  e_state = 32'd2;
    chk("state",   32'(O_state), e_state);
    chk("match",   32'(O_match), 32'(m_armed && m_trig >= 0 && k == 1));
    chk("cap_en",  32'(O_capture_enable), 32'(e_state == 32'd3));
    chk("armed",   32'(O_armed), 32'(e_state != 32'd0));
  endtask

  task automatic idle(input int n);
    I_pm_wr = 0; I_capture_now = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [7:0] b);
    I_pm_data = b; I_pm_wr = 1;
    tick();
    I_pm_wr = 0;
  endtask

  task automatic disarm();
    I_arm = 0;
    idle(2);
  endtask

  initial begin
    int len;
    m_armed = 0; m_arm_prev = 0; m_trig = -1; m_cyc = 0; m_D = 0;
    m_pat = '0; m_mask = '0;
    reset_i = 1; I_pm_data = '0; I_pm_wr = 0; I_arm = 0;
    I_pattern = '0; I_mask = '0; I_trigger_delay = '0; I_capture_now = 0;
    idle(2);
    chk("rst_state", 32'(O_state), 32'd0);
    chk("rst_cap",   32'(O_capture_enable), 32'd0);
    reset_i = 0;
    idle(1);

    // Two-byte pattern, no delay
    I_pattern = 64'h0000_0000_0000_A55A; I_mask = 64'h0000_0000_0000_FFFF;
    I_trigger_delay = '0; I_arm = 1;
    idle(1); wr(8'h00); wr(8'hA5); wr(8'h5A); idle(5);
    chk("p1_cap_held", 32'(O_capture_enable), 32'd1);
    disarm();

    // Same pattern, delay 5
    I_trigger_delay = DW'(5); I_arm = 1;
    idle(1); wr(8'h00); wr(8'hA5); wr(8'h5A); idle(10);
    disarm();

    // All-zero mask matches on first armed cycle
    I_mask = '0; I_trigger_delay = '0; I_arm = 1;
    idle(4); disarm();

    // Partial nibble mask
    I_pattern = 64'h30; I_mask = 64'hF0; I_arm = 1;
    idle(1); wr(8'h4F); idle(2);
    chk("p4_nomatch_state", 32'(O_state), 32'd1);
    wr(8'h3F); idle(3); disarm();

    // Three-byte pattern; fill flags block early match; later pattern change ignored
    I_pattern = 64'h11_2233; I_mask = 64'hFF_FFFF; I_arm = 1;
    idle(1); wr(8'h11); wr(8'h22); idle(3);
    I_pattern = 64'hDEAD_BEEF;
    wr(8'h33); idle(3); disarm();

    // Force capture with delay 3
    I_pattern = 64'h77; I_mask = 64'hFF; I_trigger_delay = DW'(3); I_arm = 1;
    idle(2); I_capture_now = 1; tick(); idle(6); disarm();

    // Disarm during DELAY
    I_mask = '0; I_trigger_delay = DW'(10); I_arm = 1;
    idle(4); I_arm = 0; idle(12);

    // Reset while in CAPTURE
    I_trigger_delay = '0; I_arm = 1;
    idle(3);
    reset_i = 1; tick();
    chk("rst_cap_state", 32'(O_state), 32'd0);
    chk("rst_cap_match", 32'(O_match), 32'd0);
    reset_i = 0; I_arm = 0; idle(2);

    // Randomized rounds
    for (int r = 0; r < 60; r++) begin
      I_pattern = {$urandom, $urandom};
      I_mask = '0;
      for (int b = 0; b < 3; b++) begin
        logic [7:0] mb;
        case ($urandom_range(0, 3))
          0: mb = 8'h00;
          1: mb = 8'hFF;
          2: mb = 8'hF0;
          default: mb = 8'h0F;
        endcase
        I_mask[8*b +: 8] = mb;
        I_pattern[8*b +: 8] = 8'($urandom_range(0, 3));
      end
      I_trigger_delay = DW'($urandom_range(0, 4));
      I_pm_wr = 1'($urandom_range(0, 1)); I_pm_data = 8'($urandom_range(0, 3));
      tick();
      I_arm = 1;
      len = int'($urandom_range(6, 25));
      for (int c = 0; c < len; c++) begin
        I_pm_wr       = 1'($urandom_range(0, 1));
        I_pm_data     = 8'($urandom_range(0, 3));
        I_capture_now = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0) I_pattern = {$urandom, $urandom};
        if ($urandom_range(0, 39) == 0) I_arm = 0;
        tick();
      end
      disarm();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
